reorder_buffer: RTL and testbench

//  Two-wide in-order-retire reorder buffer directly downstream of rename.
//  Per cycle: accepts up to two renamed instructions, records completion from
//  two writeback ports, and retires up to two completed instructions in program order.
//  On retire, returns each instruction's previous physical mapping (old_phy) to the free pool.

---
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reorder_buffer : two-wide allocate / two-port writeback / two-wide in-order
//                  retire ROB; retire returns old physical mappings.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid_a,
  input  logic [AREG_W-1:0] alloc_rd_arch_a,
  input  logic [PREG_W-1:0] alloc_rd_phy_a,
  input  logic [PREG_W-1:0] alloc_old_phy_a,
  input  logic              alloc_valid_b,
  input  logic [AREG_W-1:0] alloc_rd_arch_b,
  input  logic [PREG_W-1:0] alloc_rd_phy_b,
  input  logic [PREG_W-1:0] alloc_old_phy_b,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_a,
  output logic [IDX_W-1:0]  alloc_idx_b,
  input  logic              wb_valid_0,
  input  logic [IDX_W-1:0]  wb_idx_0,
  input  logic              wb_valid_1,
  input  logic [IDX_W-1:0]  wb_idx_1,
  output logic              ret_valid_a,
  output logic              ret_valid_b,
  output logic [AREG_W-1:0] ret_rd_arch_a,
  output logic [AREG_W-1:0] ret_rd_arch_b,
  output logic [PREG_W-1:0] ret_rd_phy_a,
  output logic [PREG_W-1:0] ret_rd_phy_b,
  output logic              ret_free_valid_a,
  output logic              ret_free_valid_b,
  output logic [PREG_W-1:0] ret_free_phy_a,
  output logic [PREG_W-1:0] ret_free_phy_b,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [AREG_W-1:0] rd_arch_q [DEPTH];
  logic [AREG_W-1:0] rd_arch_d [DEPTH];
  logic [PREG_W-1:0] rd_phy_q  [DEPTH];
  logic [PREG_W-1:0] rd_phy_d  [DEPTH];
  logic [PREG_W-1:0] old_phy_q [DEPTH];
  logic [PREG_W-1:0] old_phy_d [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt, tail_nxt;
  logic [IDX_W:0]   count_q, count_d;
  logic             do_alloc_a, do_alloc_b, ret0, ret1;
  logic [1:0]       n_alloc, n_ret;

  logic              ret_valid_a_q, ret_valid_a_d, ret_valid_b_q, ret_valid_b_d;
  logic              ret_free_valid_a_q, ret_free_valid_a_d;
  logic              ret_free_valid_b_q, ret_free_valid_b_d;
  logic [AREG_W-1:0] ret_rd_arch_a_q, ret_rd_arch_a_d, ret_rd_arch_b_q, ret_rd_arch_b_d;
  logic [PREG_W-1:0] ret_rd_phy_a_q, ret_rd_phy_a_d, ret_rd_phy_b_q, ret_rd_phy_b_d;
  logic [PREG_W-1:0] ret_free_phy_a_q, ret_free_phy_a_d, ret_free_phy_b_q, ret_free_phy_b_d;

  always_comb begin
    head_nxt   = head_q + IDX_W'(1);
    tail_nxt   = tail_q + IDX_W'(1);
    // Readiness uses start-of-cycle occupancy so same-cycle retires never widen it.
    alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
    do_alloc_a = alloc_ready & alloc_valid_a;
    do_alloc_b = do_alloc_a & alloc_valid_b;
    ret0       = valid_q[head_q] & done_q[head_q];
    ret1       = ret0 & valid_q[head_nxt] & done_q[head_nxt];
    n_alloc    = {1'b0, do_alloc_a} + {1'b0, do_alloc_b};
    n_ret      = {1'b0, ret0} + {1'b0, ret1};

    valid_d   = valid_q;
    done_d    = done_q;
    rd_arch_d = rd_arch_q;
    rd_phy_d  = rd_phy_q;
    old_phy_d = old_phy_q;

    if (wb_valid_0 && valid_q[wb_idx_0]) done_d[wb_idx_0] = 1'b1;
    if (wb_valid_1 && valid_q[wb_idx_1]) done_d[wb_idx_1] = 1'b1;

    if (ret0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (ret1) begin
      valid_d[head_nxt] = 1'b0;
      done_d[head_nxt]  = 1'b0;
    end

    // Allocation targets free slots only, so it never collides with retiring entries.
    if (do_alloc_a) begin
      valid_d[tail_q]   = 1'b1;
      done_d[tail_q]    = 1'b0;
      rd_arch_d[tail_q] = alloc_rd_arch_a;
      rd_phy_d[tail_q]  = alloc_rd_phy_a;
      old_phy_d[tail_q] = alloc_old_phy_a;
    end
    if (do_alloc_b) begin
      valid_d[tail_nxt]   = 1'b1;
      done_d[tail_nxt]    = 1'b0;
      rd_arch_d[tail_nxt] = alloc_rd_arch_b;
      rd_phy_d[tail_nxt]  = alloc_rd_phy_b;
      old_phy_d[tail_nxt] = alloc_old_phy_b;
    end

    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = tail_q + IDX_W'(n_alloc);
    count_d = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);

    ret_valid_a_d      = ret0;
    ret_valid_b_d      = ret1;
    ret_free_valid_a_d = ret0 & (|rd_phy_q[head_q]) & (|old_phy_q[head_q]);
    ret_free_valid_b_d = ret1 & (|rd_phy_q[head_nxt]) & (|old_phy_q[head_nxt]);
    ret_rd_arch_a_d    = ret0 ? rd_arch_q[head_q]   : ret_rd_arch_a_q;
    ret_rd_phy_a_d     = ret0 ? rd_phy_q[head_q]    : ret_rd_phy_a_q;
    ret_free_phy_a_d   = ret0 ? old_phy_q[head_q]   : ret_free_phy_a_q;
    ret_rd_arch_b_d    = ret1 ? rd_arch_q[head_nxt] : ret_rd_arch_b_q;
    ret_rd_phy_b_d     = ret1 ? rd_phy_q[head_nxt]  : ret_rd_phy_b_q;
    ret_free_phy_b_d   = ret1 ? old_phy_q[head_nxt] : ret_free_phy_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q            <= '0;
      done_q             <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      ret_valid_a_q      <= 1'b0;
      ret_valid_b_q      <= 1'b0;
      ret_free_valid_a_q <= 1'b0;
      ret_free_valid_b_q <= 1'b0;
      ret_rd_arch_a_q    <= '0;
      ret_rd_arch_b_q    <= '0;
      ret_rd_phy_a_q     <= '0;
      ret_rd_phy_b_q     <= '0;
      ret_free_phy_a_q   <= '0;
      ret_free_phy_b_q   <= '0;
    end else begin
      valid_q            <= valid_d;
      done_q             <= done_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      ret_valid_a_q      <= ret_valid_a_d;
      ret_valid_b_q      <= ret_valid_b_d;
      ret_free_valid_a_q <= ret_free_valid_a_d;
      ret_free_valid_b_q <= ret_free_valid_b_d;
      ret_rd_arch_a_q    <= ret_rd_arch_a_d;
      ret_rd_arch_b_q    <= ret_rd_arch_b_d;
      ret_rd_phy_a_q     <= ret_rd_phy_a_d;
      ret_rd_phy_b_q     <= ret_rd_phy_b_d;
      ret_free_phy_a_q   <= ret_free_phy_a_d;
      ret_free_phy_b_q   <= ret_free_phy_b_d;
    end
  end

  // Payload fields are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    rd_arch_q <= rd_arch_d;
    rd_phy_q  <= rd_phy_d;
    old_phy_q <= old_phy_d;
  end

  assign alloc_idx_a      = tail_q;
  assign alloc_idx_b      = tail_nxt;
  assign count            = count_q;
  assign empty            = (count_q == '0);
  assign ret_valid_a      = ret_valid_a_q;
  assign ret_valid_b      = ret_valid_b_q;
  assign ret_rd_arch_a    = ret_rd_arch_a_q;
  assign ret_rd_arch_b    = ret_rd_arch_b_q;
  assign ret_rd_phy_a     = ret_rd_phy_a_q;
  assign ret_rd_phy_b     = ret_rd_phy_b_q;
  assign ret_free_valid_a = ret_free_valid_a_q;
  assign ret_free_valid_b = ret_free_valid_b_q;
  assign ret_free_phy_a   = ret_free_phy_a_q;
  assign ret_free_phy_b   = ret_free_phy_b_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reorder_buffer : directed stimulus with a retire scoreboard.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid_a, alloc_valid_b;
  logic [4:0] alloc_rd_arch_a, alloc_rd_arch_b;
  logic [5:0] alloc_rd_phy_a, alloc_rd_phy_b, alloc_old_phy_a, alloc_old_phy_b;
  logic       alloc_ready;
  logic [3:0] alloc_idx_a, alloc_idx_b;
  logic       wb_valid_0, wb_valid_1;
  logic [3:0] wb_idx_0, wb_idx_1;
  logic       ret_valid_a, ret_valid_b, ret_free_valid_a, ret_free_valid_b;
  logic [4:0] ret_rd_arch_a, ret_rd_arch_b;
  logic [5:0] ret_rd_phy_a, ret_rd_phy_b, ret_free_phy_a, ret_free_phy_b;
  logic [4:0] count;
  logic       empty;

  reorder_buffer #(.DEPTH(16), .IDX_W(4), .PREG_W(6), .AREG_W(5)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid_a(alloc_valid_a), .alloc_rd_arch_a(alloc_rd_arch_a),
    .alloc_rd_phy_a(alloc_rd_phy_a), .alloc_old_phy_a(alloc_old_phy_a),
    .alloc_valid_b(alloc_valid_b), .alloc_rd_arch_b(alloc_rd_arch_b),
    .alloc_rd_phy_b(alloc_rd_phy_b), .alloc_old_phy_b(alloc_old_phy_b),
    .alloc_ready(alloc_ready), .alloc_idx_a(alloc_idx_a), .alloc_idx_b(alloc_idx_b),
    .wb_valid_0(wb_valid_0), .wb_idx_0(wb_idx_0),
    .wb_valid_1(wb_valid_1), .wb_idx_1(wb_idx_1),
    .ret_valid_a(ret_valid_a), .ret_valid_b(ret_valid_b),
    .ret_rd_arch_a(ret_rd_arch_a), .ret_rd_arch_b(ret_rd_arch_b),
    .ret_rd_phy_a(ret_rd_phy_a), .ret_rd_phy_b(ret_rd_phy_b),
    .ret_free_valid_a(ret_free_valid_a), .ret_free_valid_b(ret_free_valid_b),
    .ret_free_phy_a(ret_free_phy_a), .ret_free_phy_b(ret_free_phy_b),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] arch;
    logic [5:0] phy;
    logic       fv;
    logic [5:0] fp;
  } exp_t;

  exp_t       sbq[$];
  int         idxq[$];
  logic [3:0] mtail;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] arch, input logic [5:0] phy, input logic [5:0] old);
    exp_t e;
    e.arch = arch;
    e.phy  = phy;
    e.fv   = (phy != 6'd0) && (old != 6'd0);
    e.fp   = old;
    return e;
  endfunction

  task automatic chk_ret(input string slot, input logic [4:0] arch, input logic [5:0] phy,
                         input logic fv, input logic [5:0] fp);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_retire_%s: got arch %0d phy %0d, required no retire", slot, arch, phy);
    end else begin
      e = sbq.pop_front();
      if (arch !== e.arch || phy !== e.phy || fv !== e.fv || fp !== e.fp) begin
        errors++;
        $display("FAIL retire_%s: got arch %0d phy %0d fv %0d fp %0d, required arch %0d phy %0d fv %0d fp %0d",
                 slot, arch, phy, fv, fp, e.arch, e.phy, e.fv, e.fp);
      end
    end
  endtask

  // Monitor: every retire strobe consumes the oldest expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (ret_valid_b && !ret_valid_a) begin
        checks++;
        errors++;
        $display("FAIL ret_b_without_a: got b=1 a=0, required a=1");
      end
      if (ret_valid_a) chk_ret("a", ret_rd_arch_a, ret_rd_phy_a, ret_free_valid_a, ret_free_phy_a);
      if (ret_valid_b) chk_ret("b", ret_rd_arch_b, ret_rd_phy_b, ret_free_valid_b, ret_free_phy_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic va, input logic [4:0] aa, input logic [5:0] pa, input logic [5:0] oa,
                       input logic vb, input logic [4:0] ab, input logic [5:0] pb, input logic [5:0] ob,
                       input logic exp_ready);
    logic [3:0] nb;
    nb = mtail + 4'd1;
    check("alloc_ready", {31'd0, alloc_ready}, {31'd0, exp_ready});
    check("alloc_idx_a", {28'd0, alloc_idx_a}, {28'd0, mtail});
    check("alloc_idx_b", {28'd0, alloc_idx_b}, {28'd0, nb});
    alloc_valid_a = va; alloc_rd_arch_a = aa; alloc_rd_phy_a = pa; alloc_old_phy_a = oa;
    alloc_valid_b = vb; alloc_rd_arch_b = ab; alloc_rd_phy_b = pb; alloc_old_phy_b = ob;
    if (exp_ready && va) begin
      sbq.push_back(mk(aa, pa, oa));
      idxq.push_back(int'(mtail));
      mtail = mtail + 4'd1;
      if (vb) begin
        sbq.push_back(mk(ab, pb, ob));
        idxq.push_back(int'(mtail));
        mtail = mtail + 4'd1;
      end
    end
    step();
    alloc_valid_a = 1'b0;
    alloc_valid_b = 1'b0;
  endtask

  // Deterministic payload per sequence number; every fifth entry has old_phy 0.
  task automatic alloc_seq(input int sa, input logic vb, input int sb, input logic exp_ready);
    alloc(1'b1, 5'((sa % 31) + 1), 6'(16 + (sa % 40)), (sa % 5 == 4) ? 6'd0 : 6'(1 + (sa % 14)),
          vb,   5'((sb % 31) + 1), 6'(16 + (sb % 40)), (sb % 5 == 4) ? 6'd0 : 6'(1 + (sb % 14)),
          exp_ready);
  endtask

  task automatic wb_raw(input logic [3:0] idx);
    wb_valid_0 = 1'b1; wb_idx_0 = idx;
    step();
    wb_valid_0 = 1'b0;
  endtask

  task automatic wb_next(input int n);
    wb_valid_0 = 1'b1; wb_idx_0 = 4'(idxq.pop_front());
    if (n > 1) begin
      wb_valid_1 = 1'b1; wb_idx_1 = 4'(idxq.pop_front());
    end
    step();
    wb_valid_0 = 1'b0;
    wb_valid_1 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check({name, "_drain_left"}, sbq.size(), 0);
    step();
  endtask

  initial begin
    int s;
    reset = 1'b1;
    alloc_valid_a = 0; alloc_valid_b = 0;
    alloc_rd_arch_a = 0; alloc_rd_phy_a = 0; alloc_old_phy_a = 0;
    alloc_rd_arch_b = 0; alloc_rd_phy_b = 0; alloc_old_phy_b = 0;
    wb_valid_0 = 0; wb_valid_1 = 0; wb_idx_0 = 0; wb_idx_1 = 0;
    mtail = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ret_valid_a", ret_valid_a, 0);
    check("rst_ret_valid_b", ret_valid_b, 0);
    check("rst_ret_free_valid_a", ret_free_valid_a, 0);

    // Pair allocation at indices 0/1.
    alloc(1, 5'd5, 6'd32, 6'd5, 1, 5'd6, 6'd33, 6'd6, 1);
    check("t1_count", count, 2);
    check("t1_empty", empty, 0);

    // Younger completes first: nothing retires until the head is done.
    wb_raw(4'd1);
    step();
    check("t2_no_retire", ret_valid_a, 0);
    check("t2_count_hold", count, 2);
    wb_raw(4'd0);
    check("t2_not_yet", ret_valid_a, 0);
    step();
    check("t2_ret_a", ret_valid_a, 1);
    check("t2_ret_b", ret_valid_b, 1);
    check("t2_free_a", ret_free_phy_a, 5);
    check("t2_free_b", ret_free_phy_b, 6);
    check("t2_count", count, 0);
    check("t2_empty", empty, 1);
    step();
    check("t2_strobe_drop", ret_valid_a, 0);
    check("t2_field_hold", ret_free_phy_a, 5);

    // Store with no destination never frees a register.
    alloc(1, 5'd0, 6'd0, 6'd7, 0, 5'd0, 6'd0, 6'd0, 1);
    wb_raw(4'd2);
    step();
    check("t3_ret_a", ret_valid_a, 1);
    check("t3_ret_b", ret_valid_b, 0);
    check("t3_free_valid", ret_free_valid_a, 0);
    check("t3_count", count, 0);
    idxq.delete();

    // Fill to capacity around the ready threshold.
    s = 100;
    for (int i = 0; i < 7; i++) begin
      alloc_seq(s, 1, s + 1, 1);
      s += 2;
    end
    check("t4_count14", count, 14);
    alloc_seq(s, 0, 0, 1);
    s++;
    check("t4_count15", count, 15);
    alloc_seq(s, 1, s + 1, 0);
    check("t4_drop15", count, 15);
    wb_next(1);
    step();
    check("t4_count_after_ret1", count, 14);
    alloc_seq(s, 1, s + 1, 1);
    s += 2;
    check("t4_count16", count, 16);
    alloc_seq(s, 1, s + 1, 0);
    check("t4_drop16", count, 16);
    wb_next(2);
    step();
    check("t4_count_after_ret2", count, 14);
    check("t4_ready_again", alloc_ready, 1);
    while (idxq.size() > 0) wb_next(idxq.size() > 1 ? 2 : 1);
    wait_drain("t4");
    check("t4_count_final", count, 0);

    // Ten pair rounds: tail walks 4..22 so indices wrap past 15 back to 0.
    for (int r = 0; r < 10; r++) begin
      alloc_seq(s, 1, s + 1, 1);
      s += 2;
      wb_next(2);
      wait_drain("t5");
    end
    check("t5_count", count, 0);
    check("t5_tail", alloc_idx_a, 8);

    // Reset with seven live entries, two already done.
    for (int i = 0; i < 3; i++) begin
      alloc_seq(s, 1, s + 1, 1);
      s += 2;
    end
    alloc_seq(s, 0, 0, 1);
    s++;
    check("t6_count7", count, 7);
    wb_next(2);
    reset = 1'b1;
    sbq.delete();
    idxq.delete();
    mtail = 4'd0;
    step();
    reset = 1'b0;
    check("t6_count", count, 0);
    check("t6_ret_valid", ret_valid_a, 0);
    check("t6_idx_a", alloc_idx_a, 0);
    check("t6_empty", empty, 1);
    step();
    step();
    check("t6_still_idle", ret_valid_a, 0);
    alloc_seq(s, 1, s + 1, 1);
    wb_next(2);
    wait_drain("t6");
    check("t6_count_final", count, 0);

    check("final_scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
